// File: rtl/gelato_register_bank_responder_if.sv
// Collect request/response and writeback bundle between the operand collector
// (master) and the register bank responder (slave).
interface gelato_register_bank_responder_if #(
    parameter int BANK_NUM       = 4,
    parameter int ENTRY_NUM      = 4,
    parameter int COLLECTOR_SIZE = 8,
    parameter int REG_ADDR_W     = 5,
    parameter int DATA_WIDTH     = 32
);
    localparam int CIDX_W = $clog2(COLLECTOR_SIZE);

    logic                              req_valid;
    logic                              req_ready;
    logic [ENTRY_NUM-1:0]              req_entry_valid;
    logic [ENTRY_NUM*3*REG_ADDR_W-1:0] req_reg_num;
    logic [ENTRY_NUM*3-1:0]            req_reg_valid;
    logic [ENTRY_NUM*CIDX_W-1:0]       req_collector_num;
    logic                              resp_valid;
    logic                              resp_ready;
    logic [BANK_NUM-1:0]               resp_data_valid;
    logic [BANK_NUM*CIDX_W-1:0]        resp_collector_index;
    logic [BANK_NUM*2-1:0]             resp_reg_index;
    logic [BANK_NUM*DATA_WIDTH-1:0]    resp_data;
    logic                              wr_valid;
    logic [REG_ADDR_W-1:0]             wr_addr;
    logic [DATA_WIDTH-1:0]             wr_data;

    modport master (
        output req_valid, req_entry_valid, req_reg_num, req_reg_valid, req_collector_num,
        output resp_ready, wr_valid, wr_addr, wr_data,
        input  req_ready, resp_valid, resp_data_valid, resp_collector_index,
        input  resp_reg_index, resp_data
    );

    modport slave (
        input  req_valid, req_entry_valid, req_reg_num, req_reg_valid, req_collector_num,
        input  resp_ready, wr_valid, wr_addr, wr_data,
        output req_ready, resp_valid, resp_data_valid, resp_collector_index,
        output resp_reg_index, resp_data
    );
endinterface

// File: rtl/gelato_register_bank_responder.sv
// Banked register file responder: one arbitrated read per bank per collect round.
// Optional macro WRITE_BYPASS_EN forwards a same-cycle write into the ARB read.
module gelato_register_bank_responder #(
    parameter int BANK_NUM       = 4,
    parameter int ENTRY_NUM      = 4,
    parameter int COLLECTOR_SIZE = 8,
    parameter int REG_ADDR_W     = 5,
    parameter int DATA_WIDTH     = 32
) (
    input logic                            clk,
    input logic                            rst,
    input logic                            rdy,
    gelato_register_bank_responder_if.slave bus
);
    localparam int BANK_W = $clog2(BANK_NUM);
    localparam int CIDX_W = $clog2(COLLECTOR_SIZE);
    localparam int ROW_W  = REG_ADDR_W - BANK_W;
    localparam int ROWS   = 1 << ROW_W;
    localparam int OPS    = ENTRY_NUM * 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_READ = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                              state_r;
    logic                                req_ready_r;
    logic                                resp_valid_r;
    logic [BANK_NUM-1:0]                 resp_dv_r;
    logic [BANK_NUM-1:0][CIDX_W-1:0]     resp_cidx_r;
    logic [BANK_NUM-1:0][1:0]            resp_ridx_r;
    logic [BANK_NUM-1:0][DATA_WIDTH-1:0] resp_data_r;

    logic [ENTRY_NUM-1:0]                entry_valid_r;
    logic [OPS*REG_ADDR_W-1:0]           reg_num_r;
    logic [OPS-1:0]                      reg_valid_r;
    logic [ENTRY_NUM*CIDX_W-1:0]         cidx_r;

    logic [DATA_WIDTH-1:0]               mem_r [BANK_NUM][ROWS];

    logic [BANK_NUM-1:0]                 grant_s;
    logic [BANK_NUM-1:0][ROW_W-1:0]      grant_row_s;
    logic [BANK_NUM-1:0][CIDX_W-1:0]     grant_cidx_s;
    logic [BANK_NUM-1:0][1:0]            grant_ridx_s;
    logic [REG_ADDR_W-1:0]               cand_addr_s;

    logic [BANK_NUM-1:0]                 rd_hit_r;
    logic [BANK_NUM-1:0][CIDX_W-1:0]     rd_cidx_r;
    logic [BANK_NUM-1:0][1:0]            rd_ridx_r;
    logic [BANK_NUM-1:0][DATA_WIDTH-1:0] rd_data_r;

    logic [BANK_W-1:0]                   wr_bank_s;
    logic [ROW_W-1:0]                    wr_row_s;

    assign wr_bank_s = bus.wr_addr[BANK_W-1:0];
    assign wr_row_s  = bus.wr_addr[REG_ADDR_W-1:BANK_W];

    assign bus.req_ready            = req_ready_r;
    assign bus.resp_valid           = resp_valid_r;
    assign bus.resp_data_valid      = resp_dv_r;
    assign bus.resp_collector_index = resp_cidx_r;
    assign bus.resp_reg_index       = resp_ridx_r;
    assign bus.resp_data            = resp_data_r;

    // Per-bank fixed-priority pick: slot 0 first, operand 1..3 within a slot.
    always_comb begin
        grant_s      = {BANK_NUM{1'b0}};
        grant_row_s  = '0;
        grant_cidx_s = '0;
        grant_ridx_s = '0;
        cand_addr_s  = {REG_ADDR_W{1'b0}};
        for (int b = 0; b < BANK_NUM; b++) begin
            for (int e = 0; e < ENTRY_NUM; e++) begin
                for (int r = 0; r < 3; r++) begin
                    cand_addr_s = reg_num_r[(e*3+r)*REG_ADDR_W +: REG_ADDR_W];
                    if (!grant_s[b] && entry_valid_r[e] && reg_valid_r[e*3+r] &&
                        (cand_addr_s[BANK_W-1:0] == BANK_W'(b))) begin
                        grant_s[b]      = 1'b1;
                        grant_row_s[b]  = cand_addr_s[REG_ADDR_W-1:BANK_W];
                        grant_cidx_s[b] = cidx_r[e*CIDX_W +: CIDX_W];
                        grant_ridx_s[b] = 2'(r + 1);
                    end else begin
                        grant_s[b] = grant_s[b];
                    end
                end
            end
        end
    end

    // Register file contents and the writeback port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                for (int i = 0; i < ROWS; i++) begin
                    mem_r[b][i] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else if (rdy && bus.wr_valid) begin
            mem_r[wr_bank_s][wr_row_s] <= bus.wr_data;
        end
    end

    // Round sequencer: latch request, arbitrate and read, present, await accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            req_ready_r   <= 1'b1;
            resp_valid_r  <= 1'b0;
            resp_dv_r     <= {BANK_NUM{1'b0}};
            resp_cidx_r   <= '0;
            resp_ridx_r   <= '0;
            resp_data_r   <= '0;
            entry_valid_r <= {ENTRY_NUM{1'b0}};
            reg_num_r     <= {(OPS*REG_ADDR_W){1'b0}};
            reg_valid_r   <= {OPS{1'b0}};
            cidx_r        <= {(ENTRY_NUM*CIDX_W){1'b0}};
            rd_hit_r      <= {BANK_NUM{1'b0}};
            rd_cidx_r     <= '0;
            rd_ridx_r     <= '0;
            rd_data_r     <= '0;
        end else if (rdy) begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        entry_valid_r <= bus.req_entry_valid;
                        reg_num_r     <= bus.req_reg_num;
                        reg_valid_r   <= bus.req_reg_valid;
                        cidx_r        <= bus.req_collector_num;
                        req_ready_r   <= 1'b0;
                        state_r       <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    for (int b = 0; b < BANK_NUM; b++) begin
                        rd_hit_r[b]  <= grant_s[b];
                        rd_cidx_r[b] <= grant_cidx_s[b];
                        rd_ridx_r[b] <= grant_ridx_s[b];
                        if (!grant_s[b]) begin
                            rd_data_r[b] <= {DATA_WIDTH{1'b0}};
`ifdef WRITE_BYPASS_EN
                        end else if (bus.wr_valid && (wr_bank_s == BANK_W'(b)) &&
                                     (wr_row_s == grant_row_s[b])) begin
                            rd_data_r[b] <= bus.wr_data;
`endif
                        end else begin
                            rd_data_r[b] <= mem_r[b][grant_row_s[b]];
                        end
                    end
                    state_r <= ST_READ;
                end
                ST_READ: begin
                    resp_dv_r    <= rd_hit_r;
                    resp_cidx_r  <= rd_cidx_r;
                    resp_ridx_r  <= rd_ridx_r;
                    resp_data_r  <= rd_data_r;
                    resp_valid_r <= 1'b1;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/gelato_register_bank_responder.md
Name: gelato_register_bank_responder

Overview:
- Responder end of the register collect request/response protocol; the operand collector is the initiator.
- Accepts one collect round of up to ENTRY_NUM collector entries, each with 3 source operands.
- Arbitrates one read per register bank per round, reads the banked register file and returns one response beat carrying at most one operand per bank.
- Operands not granted are dropped; the collector re-requests them in a later round. Also owns the register file write port used by writeback.

Parameters:
- BANK_NUM, 4, number of register banks; power of two.
- ENTRY_NUM, 4, request slots per round.
- COLLECTOR_SIZE, 8, collector entries; CIDX_W = $clog2(COLLECTOR_SIZE).
- REG_ADDR_W, 5, physical register address width.
- DATA_WIDTH, 32, operand width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; when low all state holds.
- req_valid  in  1  collect request valid.
- req_ready  out  1  responder idle, can accept a request.
- req_entry_valid  in  ENTRY_NUM  slot e holds a live entry.
- req_reg_num  in  ENTRY_NUM*3*REG_ADDR_W  physical address, slot e, operand r (r=1..3 packed as 0..2).
- req_reg_valid  in  ENTRY_NUM*3  operand still needs data.
- req_collector_num  in  ENTRY_NUM*CIDX_W  collector index of slot e.
- resp_valid  out  1  response beat valid.
- resp_ready  in  1  collector accepts beat.
- resp_data_valid  out  BANK_NUM  bank b lane carries data.
- resp_collector_index  out  BANK_NUM*CIDX_W  destination entry per lane.
- resp_reg_index  out  BANK_NUM*2  operand index 1..3 per lane.
- resp_data  out  BANK_NUM*DATA_WIDTH  operand data per lane.
- wr_valid  in  1  writeback enable.
- wr_addr  in  REG_ADDR_W  writeback address.
- wr_data  in  DATA_WIDTH  writeback data.

Behaviour:
- Bank mapping: bank = addr[$clog2(BANK_NUM)-1:0]; row = remaining upper bits. Each bank is a 1R1W array of 2^REG_ADDR_W/BANK_NUM rows.
- Reset: state IDLE, req_ready=1, resp_valid=0, all resp_* fields=0, all register contents=0. Reset mid-round discards the in-flight round with no response.
- rdy=0: FSM, outputs, arrays and writes all frozen.
- IDLE: req_ready=1. A request fires on req_valid&&req_ready. On fire, latch all req_* fields and go to ARB; req_ready drops in the next cycle.
- ARB (one cycle): per bank, grant the first candidate in scan order slot 0..ENTRY_NUM-1, operand 1..3.
  - Candidate condition: req_entry_valid[e] && req_reg_valid[e][r] && bank(addr)==b.
  - Issue the bank read, then go to READ.
  - At most one grant per bank; a candidate granted to one bank is never granted to another.
- READ: the registered read data lands in the resp_* lanes and the FSM moves to RESP. Non-granted lanes: data_valid=0, index and data fields=0.
- RESP: resp_valid=1; all fields held stable until resp_ready. On resp_valid&&resp_ready, go to IDLE next cycle with resp_valid=0.
- Latency: request fires cycle T, resp_valid=1 at T+3; minimum round period is 4 cycles.
- A request with no valid operands still completes a round and returns all data_valid=0.
- Writes are accepted in any state. A write to row X of bank b in the same cycle as an ARB read of that row returns the old value unless WRITE_BYPASS_EN is defined.
- Address 0 is an ordinary location. The collector never marks x0 operands valid, so no special case is needed here.

Optional Feature:
- WRITE_BYPASS_EN defined: a same-cycle write to the address being read in ARB forwards wr_data into the response lane.
- Not defined: the read returns the pre-write value; the new value is visible from the next round onward.

Test Plan:
- Reset, write addr 5=0xDEADBEEF. Request slot0 valid, collector_num 3, rs1=5 valid, rs2/rs3 invalid -> at T+3 resp_valid=1, lane1 data_valid=1, collector_index=3, reg_index=1, data=0xDEADBEEF; other lanes 0.
- Conflict: slot0 rs1=4, slot1 rs2=8 (both bank0) -> lane0 returns slot0/rs1 only. Re-request slot1 alone -> lane0 returns slot1/rs2.
- Full spread: slot0 rs1..3=1,2,3 and slot1 rs1=4 -> lanes 0..3 all valid with correct index pairs in one beat.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and all fields stable, req_ready=0. Assert resp_ready -> req_ready=1 next cycle.
- Bypass: write addr 6=0x1234 in the ARB cycle of a read of addr 6 holding 0x0 -> response 0x1234 with WRITE_BYPASS_EN, 0x0 without.
- Assert rst in the READ cycle -> resp_valid never rises, req_ready=1, a subsequent read returns 0.
